usb_tx_serializer: RTL and testbench

Full-speed USB transmit serializer: the transmit end of the bit-level path whose receive side deserializes through the flex shift register. It accepts packet bytes over a valid/ready handshake, prepends SYNC, shifts each byte out LSB-first with bit stuffing and NRZI encoding, then appends EOP. It drives the D+/D- pad pair and output enable at one bit per `CLKS_PER_BIT` clocks.

---
 rtl/usb_pkg.sv | 29 ++
 rtl/usb_tx_bit_timer.sv | 32 +++
 rtl/usb_tx_serializer.sv | 146 ++++++++++++++
 tb/tb_usb_tx_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and line constants for the
// full-speed USB transmit path.
package usb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam logic [2:0] STUFF_LIMIT = 3'd6;

  // {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // A 0 toggles J<->K, a 1 holds the level.
  function automatic logic [1:0] nrzi(
    input logic [1:0] lvl,
    input logic       b
  );
    return b ? lvl : ~lvl;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period counter; bit_end marks the
// last clock of each USB bit time.
module usb_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);
  import usb_pkg::*;

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST =
    W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  // Count 0..CLKS_PER_BIT-1, held at 0 while cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end = (r_cnt == LAST);

endmodule

// File: rtl/usb_tx_serializer.sv
// USB FS transmit serializer: SYNC, LSB-first
// data with bit stuffing and NRZI, then EOP.
module usb_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_err
);
  import usb_pkg::*;

  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_idx;
  logic [2:0] r_ones;
  logic [1:0] r_line;
  logic       r_last;
  logic       r_oe;
  logic       r_busy;
  logic       r_hold;

  logic w_bit_end;
  logic w_shifting;
  logic w_stuff_due;
  logic w_byte_done;
  logic w_load_due;
  logic w_bit;

  usb_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (r_state == ST_IDLE),
    .bit_end (w_bit_end)
  );

  assign w_shifting  = (r_state == ST_SYNC) ||
                       (r_state == ST_DATA);
  assign w_stuff_due = (r_ones == STUFF_LIMIT);
  assign w_byte_done = (r_idx == 3'd7);

  // A new byte is due once the current one and
  // any trailing stuff bit have been sent.
  assign w_load_due = w_bit_end && w_byte_done &&
                      !w_stuff_due &&
                      ((r_state == ST_SYNC) ||
                       (r_state == ST_DATA && !r_last));

  // Next bit on the wire: stuff 0, next shift
  // bit, or bit 0 of the incoming byte.
  assign w_bit = w_stuff_due  ? 1'b0 :
                 !w_byte_done ? r_shift[r_idx + 3'd1] :
                                tx_data[0];

  assign tx_ready = w_load_due;
  assign tx_err   = w_load_due && !tx_valid;
  assign dp       = r_line[1];
  assign dm       = r_line[0];
  assign tx_oe    = r_oe;
  assign tx_busy  = r_busy;

  // Packet FSM, shifter, stuff counter and NRZI level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_ones  <= '0;
      r_line  <= LINE_J;
      r_last  <= 1'b0;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (tx_valid && !r_hold) begin
            r_state <= ST_SYNC;
            r_shift <= SYNC_BYTE;
            r_idx   <= '0;
            r_ones  <= '0;
            r_last  <= 1'b0;
            r_line  <= nrzi(LINE_J, SYNC_BYTE[0]);
            r_oe    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_SYNC, ST_DATA: begin
          if (w_bit_end) begin
            r_line <= nrzi(r_line, w_bit);
            r_ones <= w_bit ? r_ones + 3'd1 : 3'd0;
            if (w_stuff_due) begin
              r_idx <= r_idx;
            end else if (!w_byte_done) begin
              r_idx <= r_idx + 3'd1;
            end else if (w_load_due && tx_valid) begin
              r_state <= ST_DATA;
              r_shift <= tx_data;
              r_last  <= tx_last;
              r_idx   <= '0;
            end else begin
              r_state <= ST_EOP_SE0;
              r_line  <= LINE_SE0;
              r_idx   <= '0;
              r_ones  <= '0;
            end
          end
        end
        ST_EOP_SE0: begin
          if (w_bit_end) begin
            if (r_idx[0]) begin
              r_state <= ST_EOP_J;
              r_line  <= LINE_J;
            end else begin
              r_idx <= 3'd1;
            end
          end
        end
        ST_EOP_J: begin
          if (w_bit_end) begin
            r_state <= ST_IDLE;
            r_line  <= LINE_J;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_hold  <= 1'b1;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: directed and
// random packets against a bit-time line model.
module tb_usb_tx_serializer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, dp, dm;
  logic       tx_oe, tx_busy, tx_err;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] pkt [0:3];
  logic [1:0] eline [$];
  int         erdy [$];
  int         eerr;

  usb_tx_serializer #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .dp       (dp),
    .dm       (dm),
    .tx_oe    (tx_oe),
    .tx_busy  (tx_busy),
    .tx_err   (tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  // Line level per bit time, ready/err cycles
  // (cycle 1 = first SYNC bit).
  task automatic build(input int n, input bit und);
    logic [1:0] lvl;
    logic [7:0] byt;
    int ones;
    lvl = 2'b10;
    ones = 0;
    eline.delete();
    erdy.delete();
    eerr = -1;
    for (int s = 0; s <= n; s++) begin
      byt = (s == 0) ? 8'h80 : pkt[s-1];
      if (s > 0) erdy.push_back(CPB * eline.size());
      for (int i = 0; i < 8; i++) begin
        if (!byt[i]) lvl = ~lvl;
        eline.push_back(lvl);
        ones = byt[i] ? ones + 1 : 0;
        if (ones == 6) begin
          lvl = ~lvl;
          eline.push_back(lvl);
          ones = 0;
        end
      end
    end
    if (und) begin
      erdy.push_back(CPB * eline.size());
      eerr = CPB * eline.size();
    end
    eline.push_back(2'b00);
    eline.push_back(2'b00);
    eline.push_back(2'b10);
  endtask

  task automatic run_pkt(
    input int pk,
    input int n,
    input bit und
  );
    int T, hi;
    bit hs, rdy, oe;
    logic [1:0] ln;
    build(n, und);
    T = eline.size();
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = pkt[0];
    tx_last  = (n == 1) && !und;
    hi = 0;
    for (int c = 1; c <= CPB * T + 2; c++) begin
      @(negedge clk);
      oe = (c <= CPB * T);
      ln = oe ? eline[(c - 1) / CPB] : 2'b10;
      rdy = 1'b0;
      foreach (erdy[k]) if (erdy[k] == c) rdy = 1'b1;
      chk($sformatf("p%0d c%0d", pk, c),
          {26'd0, dp, dm, tx_oe, tx_busy,
           tx_ready, tx_err},
          {26'd0, ln, oe, oe, rdy, (c == eerr)});
      hs = tx_ready && tx_valid;
      @(posedge clk);
      #1;
      if (hs) begin
        hi++;
        if (hi < n) begin
          tx_data = pkt[hi];
          tx_last = (hi == n - 1) && !und;
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
      end
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  initial begin
    int n;
    bit und;
    repeat (3) @(negedge clk);
    chk("rst", {dp, dm, tx_oe, tx_busy, tx_ready, tx_err},
        6'b100000);
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk($sformatf("idle c%0d", c),
          {dp, dm, tx_oe, tx_busy, tx_ready, tx_err},
          6'b100000);
    end

    pkt[0] = 8'h00;
    run_pkt(0, 1, 1'b0);
    pkt[0] = 8'hFF;
    run_pkt(1, 1, 1'b0);
    pkt[0] = 8'h3F;
    pkt[1] = 8'h81;
    run_pkt(2, 2, 1'b0);
    pkt[0] = 8'hA5;
    run_pkt(3, 1, 1'b1);

    for (int p = 4; p < 16; p++) begin
      n = $urandom_range(1, 4);
      und = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 4; i++)
        pkt[i] = $urandom_range(0, 1) ? 8'hFF
                                      : 8'($urandom);
      run_pkt(p, n, und);
    end

    // Reset in the middle of a data byte.
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    tx_last  = 1'b1;
    repeat (45) @(negedge clk);
    chk("mid oe", {31'd0, tx_oe}, 32'd1);
    rst = 1'b1;
    tx_valid = 1'b0;
    #1;
    chk("mid rst",
        {dp, dm, tx_oe, tx_busy, tx_ready, tx_err},
        6'b100000);
    @(negedge clk);
    rst = 1'b0;
    pkt[0] = 8'h00;
    run_pkt(99, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
